cp0_irq_timer: RTL and testbench
================================

Name: cp0_irq_timer

Overview:
- Sits beside CP0 and feeds it: it generates the hardware interrupt-pending bits Cause.IP[7:2] and the Count/Compare timer.
- Inputs are external interrupt lines plus CP0's own mtc0 write bus.
- Outputs are the registered pending bits merged into Cause, a qualified interrupt request for CP0's exception logic, and read data for Count/Compare.

Parameters:
- NUM_HW_IRQ, 5, number of external interrupt lines; mapped to IP2..IP(1+NUM_HW_IRQ), max 5.
- EDGE_MASK, 5'b00000, per-line mode; 1 = rising-edge latched, 0 = level.
- COUNT_DIV, 2, clock cycles per Count increment (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- irqIn  in  NUM_HW_IRQ  external interrupt lines, asynchronous to clk.
- addrW  in  5  CP0 write register number.
- selW  in  6  CP0 write select.
- din  in  32  CP0 write data.
- cp0Write  in  1  CP0 write strobe.
- addrR  in  5  CP0 read register number.
- selR  in  6  CP0 read select.
- status  in  32  current (forwarded) Status from CP0.
- countStop  in  1  freeze Count (debug/halt).
- ipOut  out  6  pending bits for Cause[15:10] (IP7..IP2).
- hwIntReq  out  1  qualified hardware interrupt request.
- dout  out  32  read data for Count/Compare.
- readHit  out  1  addrR/selR selects Count or Compare.

Behaviour:
- Reset (rst low, async):
  - sync flops, edge latches, prescaler, Count, Compare, timer pending all 0.
  - ipOut=0, hwIntReq=0.
- Synchronizer: two flops per irqIn line.
  - prevSync holds last synced value for edge detect.
  - Latency irqIn -> ipOut is 3 cycles (2 sync + 1 pending register).
- Level line i: pend[i] <= sync2[i] every cycle.
- Edge line i:
  - pend[i] set on sync2 & ~prevSync.
  - Cleared by a write to Cause (addrW=13, selW=0, cp0Write) with din[10+i]=1 (write-1-to-clear).
  - Set and clear in the same cycle: set wins.
  - Level lines ignore Cause writes.
- Prescaler: counts 0..COUNT_DIV-1 while countStop=0. Count increments when prescaler==COUNT_DIV-1.
- Count arithmetic: 32-bit unsigned; 0xFFFF_FFFF -> 0x0000_0000 wraps silently.
- Count write (addrW=9, selW=0):
  - Count <= din and prescaler <= 0.
  - Write overrides a same-cycle increment.
  - Never sets timer pending, even if din==Compare.
- Compare write (addrW=11, selW=0): Compare <= din and timer pending <= 0.
- Timer pending (IP7):
  - Set in the cycle Count is incremented to a value equal to Compare.
  - Remains set until a Compare write.
  - Compare write coinciding with a match: clear wins.
- countStop=1 holds prescaler and Count. Writes still take effect.
- ipOut = {timerPend, pend[4:0]}. Unused lines read 0.
- hwIntReq (combinational from registered state and status input):
  - hwIntReq = |(ipOut & status[15:10]) & status[0] & ~status[1].
- Read port:
  - addrR=9, selR=0 -> Count, readHit=1.
  - addrR=11, selR=0 -> Compare, readHit=1.
  - Same-cycle write to the same register forwards din.
  - Otherwise dout=0, readHit=0.
- Writes with selW[2:0]!=0 are ignored.

Decomposition:
- Shared CP0 package holds register-number constants (CP0_COUNT=9, CP0_COMPARE=11, CP0_STATUS=12, CP0_CAUSE=13), Status bit positions (IE=0, EXL=1) and the Cause IP field base (10).
- One natural sub-module, cp0_irq_sync: a per-line 2-flop synchronizer plus edge/level pending cell, instantiated NUM_HW_IRQ times.
- Timer logic stays inline.

Test Plan:
- Reset release, then irqIn[0] high (level), status=0x0000_0401 -> ipOut=6'b000001 on cycle 3 and hwIntReq=1. Drop irqIn[0] -> ipOut=0 three cycles later.
- EDGE_MASK=5'b00010, single-cycle pulse on irqIn[1] -> ipOut[1] latches and stays 1. Cause write din=0x0000_0800 -> ipOut[1]=0 next cycle. Pulse coinciding with the clear leaves it set.
- Count write 0xFFFF_FFFE, COUNT_DIV=2 -> Count reads 0xFFFF_FFFF after 2 cycles, then 0x0000_0000 after 4.
- Compare=0x10, Count=0x0E -> ipOut[5] sets when Count becomes 0x10. Compare write 0x20 clears it. Count write 0x20 does not set it.
- status EXL set (0x0000_8003), timer pending -> hwIntReq=0. Clear EXL (0x0000_8001) -> hwIntReq=1.
- Assert rst mid-count with pending bits set -> all state and outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cp0_irq_timer_pkg.sv
// Shared CP0 constants: register numbers, Status bit positions and the Cause IP field base.
package cp0_irq_timer_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;

  localparam int STATUS_IE     = 0;
  localparam int STATUS_EXL    = 1;
  localparam int CAUSE_IP_BASE = 10;
  localparam int MAX_HW_IRQ    = 5;

  // Only the low three select bits qualify a register access.
  function automatic logic sel_zero(input logic [5:0] sel);
    return sel[2:0] == 3'b000;
  endfunction

endpackage

// File: rtl/cp0_irq_sync.sv
// One external interrupt line: 2-flop synchronizer, edge detect and level/edge pending cell.
module cp0_irq_sync #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic clr,
  output logic pend
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
      pend    <= 1'b0;
    end else begin
      sync_p0 <= irq;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
      // Edge mode: a new rising edge beats a same-cycle write-1-to-clear.
      if (EDGE) pend <= (sync_p1 & ~prev_p2) | (pend & ~clr);
      else      pend <= sync_p1;
    end
  end

endmodule

// File: rtl/cp0_irq_timer.sv
// Cause.IP[7:2] generation and Count/Compare timer sitting beside CP0.
module cp0_irq_timer
  import cp0_irq_timer_pkg::*;
#(
  parameter int         NUM_HW_IRQ = 5,
  parameter logic [4:0] EDGE_MASK  = 5'b00000,
  parameter int         COUNT_DIV  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_HW_IRQ-1:0] irqIn,
  input  logic [4:0]            addrW,
  input  logic [5:0]            selW,
  input  logic [31:0]           din,
  input  logic                  cp0Write,
  input  logic [4:0]            addrR,
  input  logic [5:0]            selR,
  input  logic [31:0]           status,
  input  logic                  countStop,
  output logic [5:0]            ipOut,
  output logic                  hwIntReq,
  output logic [31:0]           dout,
  output logic                  readHit
);

  localparam int             PW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(COUNT_DIV - 1);

  logic          count_wr;
  logic          compare_wr;
  logic          cause_wr;
  logic          tick;
  logic          match;
  logic [PW-1:0] presc;
  logic [31:0]   count;
  logic [31:0]   compare;
  logic [31:0]   count_inc;
  logic          timer_pend;
  logic [4:0]    pend;
  logic          unused_bits;

  assign count_wr   = cp0Write && (addrW == CP0_COUNT)   && sel_zero(selW);
  assign compare_wr = cp0Write && (addrW == CP0_COMPARE) && sel_zero(selW);
  assign cause_wr   = cp0Write && (addrW == CP0_CAUSE)   && sel_zero(selW);

  assign tick      = !countStop && (presc == PRESC_MAX);
  assign count_inc = count + 32'd1;
  assign match     = tick && !count_wr && (count_inc == compare);

  genvar i;
  generate
    for (i = 0; i < MAX_HW_IRQ; i++) begin : g_line
      if (i < NUM_HW_IRQ) begin : g_used
        cp0_irq_sync #(.EDGE(EDGE_MASK[i])) u_sync (
          .clk  (clk),
          .rst  (rst),
          .irq  (irqIn[i]),
          .clr  (cause_wr & din[CAUSE_IP_BASE + i]),
          .pend (pend[i])
        );
      end else begin : g_unused
        assign pend[i] = 1'b0;
      end
    end
  endgenerate

  // Timer state: a Count write restarts the prescaler and never raises the match.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc      <= '0;
      count      <= '0;
      compare    <= '0;
      timer_pend <= 1'b0;
    end else begin
      if (count_wr) begin
        count <= din;
        presc <= '0;
      end else if (!countStop) begin
        if (tick) begin
          count <= count_inc;
          presc <= '0;
        end else begin
          presc <= presc + PW'(1);
        end
      end

      if (compare_wr) begin
        compare    <= din;
        timer_pend <= 1'b0;
      end else if (match) begin
        timer_pend <= 1'b1;
      end
    end
  end

  assign ipOut    = {timer_pend, pend};
  assign hwIntReq = (|(ipOut & status[CAUSE_IP_BASE +: 6])) &
                    status[STATUS_IE] & ~status[STATUS_EXL];

  // Read port forwards a same-cycle write to the register being read.
  always_comb begin
    dout    = '0;
    readHit = 1'b0;
    if (sel_zero(selR)) begin
      if (addrR == CP0_COUNT) begin
        readHit = 1'b1;
        dout    = count_wr ? din : count;
      end else if (addrR == CP0_COMPARE) begin
        readHit = 1'b1;
        dout    = compare_wr ? din : compare;
      end
    end
  end

  assign unused_bits = ^{selW[5:3], selR[5:3], status[31:16], status[9:2]};

endmodule

// File: tb/tb_cp0_irq_timer.sv
// Randomized and directed stimulus against a behavioural model, checked through a scoreboard queue.
module tb_cp0_irq_timer;

  localparam int         NIRQ  = 5;
  localparam logic [4:0] EMASK = 5'b01010;
  localparam int         DIV   = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NIRQ-1:0] irqIn = '0;
  logic [4:0]      addrW = '0;
  logic [5:0]      selW = '0;
  logic [31:0]     din = '0;
  logic            cp0Write = 1'b0;
  logic [4:0]      addrR = 5'd9;
  logic [5:0]      selR = '0;
  logic [31:0]     status = 32'h0000_0401;
  logic            countStop = 1'b0;
  logic [5:0]      ipOut;
  logic            hwIntReq;
  logic [31:0]     dout;
  logic            readHit;

  cp0_irq_timer #(
    .NUM_HW_IRQ (NIRQ),
    .EDGE_MASK  (EMASK),
    .COUNT_DIV  (DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .irqIn     (irqIn),
    .addrW     (addrW),
    .selW      (selW),
    .din       (din),
    .cp0Write  (cp0Write),
    .addrR     (addrR),
    .selR      (selR),
    .status    (status),
    .countStop (countStop),
    .ipOut     (ipOut),
    .hwIntReq  (hwIntReq),
    .dout      (dout),
    .readHit   (readHit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  ip;
    logic        hw;
    logic [31:0] rd;
    logic        hit;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: pending lines derived from the history of sampled irqIn values.
  logic [4:0]  hist [4];
  logic [4:0]  m_pend;
  logic [31:0] m_count;
  logic [31:0] m_compare;
  int          m_presc;
  logic        m_tp;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) hist[k] = '0;
    m_pend    = '0;
    m_count   = '0;
    m_compare = '0;
    m_presc   = 0;
    m_tp      = 1'b0;
  endfunction

  function automatic logic wr_hit(logic [4:0] a);
    return cp0Write && (addrW == a) && (selW[2:0] == 3'b000);
  endfunction

  function automatic exp_t model_out();
    exp_t       e;
    logic [5:0] ip;
    ip    = {m_tp, m_pend};
    e.ip  = ip;
    e.hw  = (|(ip & status[15:10])) & status[0] & ~status[1];
    e.hit = 1'b0;
    e.rd  = '0;
    if (selR[2:0] == 3'b000 && addrR == 5'd9) begin
      e.hit = 1'b1;
      e.rd  = wr_hit(5'd9) ? din : m_count;
    end else if (selR[2:0] == 3'b000 && addrR == 5'd11) begin
      e.hit = 1'b1;
      e.rd  = wr_hit(5'd11) ? din : m_compare;
    end
    return e;
  endfunction

  function automatic void model_step();
    logic cw, mw, zw;
    cw = wr_hit(5'd9);
    mw = wr_hit(5'd11);
    zw = wr_hit(5'd13);
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = irqIn;
    for (int k = 0; k < 5; k++) begin
      if (EMASK[k]) begin
        if (hist[2][k] && !hist[3][k]) m_pend[k] = 1'b1;
        else if (zw && din[10 + k])    m_pend[k] = 1'b0;
      end else begin
        m_pend[k] = hist[2][k];
      end
    end
    if (cw) begin
      m_count = din;
      m_presc = 0;
    end else if (!countStop) begin
      if (m_presc == DIV - 1) begin
        m_count = m_count + 32'd1;
        m_presc = 0;
        if (m_count == m_compare && !mw) m_tp = 1'b1;
      end else begin
        m_presc++;
      end
    end
    if (mw) begin
      m_compare = din;
      m_tp      = 1'b0;
    end
  endfunction

  // Called shortly after a rising edge with inputs set; expectation for this cycle is queued.
  task automatic cycle();
    if (!rst) model_reset();
    sb.push_back(model_out());
    @(posedge clk);
    if (!rst) model_reset();
    else      model_step();
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cp0Write = 1'b1;
    addrW    = a;
    selW     = 6'd0;
    din      = d;
    cycle();
    cp0Write = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("ipOut",    {26'd0, ipOut},    {26'd0, mon_e.ip});
        check("hwIntReq", {31'd0, hwIntReq}, {31'd0, mon_e.hw});
        check("dout",     dout,              mon_e.rd);
        check("readHit",  {31'd0, readHit},  {31'd0, mon_e.hit});
      end
    end
  end

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    repeat (3) cycle();
    rst = 1'b1;

    irqIn[0] = 1'b1;
    repeat (5) cycle();
    irqIn[0] = 1'b0;
    repeat (5) cycle();

    status = 32'h0000_FC01;
    irqIn[1] = 1'b1;
    cycle();
    irqIn[1] = 1'b0;
    repeat (6) cycle();
    wr(5'd13, 32'h0000_0800);
    repeat (2) cycle();
    irqIn[1] = 1'b1;
    cycle();
    irqIn[1] = 1'b0;
    cycle();
    wr(5'd13, 32'h0000_0800);
    repeat (4) cycle();
    wr(5'd13, 32'h0000_0800);
    cycle();

    addrR = 5'd9;
    wr(5'd9, 32'hFFFF_FFFE);
    repeat (6) cycle();

    status = 32'h0000_8001;
    wr(5'd11, 32'h0000_0010);
    wr(5'd9, 32'h0000_000E);
    repeat (6) cycle();
    status = 32'h0000_8003;
    cycle();
    status = 32'h0000_8001;
    cycle();
    addrR = 5'd11;
    wr(5'd11, 32'h0000_0020);
    cycle();
    addrR = 5'd9;
    wr(5'd9, 32'h0000_0020);
    repeat (3) cycle();

    countStop = 1'b1;
    repeat (4) cycle();
    wr(5'd9, 32'h0000_0005);
    repeat (2) cycle();
    countStop = 1'b0;
    repeat (4) cycle();

    for (int k = 0; k < 400; k++) begin
      irqIn  = NIRQ'($urandom);
      status = $urandom & 32'h0000_FC03;
      if ($urandom_range(0, 3) != 0) status[0] = 1'b1;
      countStop = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       addrR = 5'd9;
        1:       addrR = 5'd11;
        2:       addrR = 5'd12;
        default: addrR = 5'd13;
      endcase
      selR     = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 7)) : 6'd0;
      cp0Write = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       addrW = 5'd9;
        1:       addrW = 5'd11;
        2:       addrW = 5'd13;
        default: addrW = 5'd12;
      endcase
      selW = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(1, 7)) : 6'd0;
      din  = (addrW == 5'd9) ? (m_compare - 32'($urandom_range(0, 3))) : $urandom;
      cycle();
    end
    cp0Write  = 1'b0;
    countStop = 1'b0;
    selR      = 6'd0;

    irqIn  = '1;
    status = 32'h0000_FC01;
    addrR  = 5'd9;
    wr(5'd11, 32'h0000_0040);
    wr(5'd9, 32'h0000_003F);
    repeat (5) cycle();
    rst = 1'b0;
    #1;
    check("async_rst_ipOut",    {26'd0, ipOut},    32'd0);
    check("async_rst_hwIntReq", {31'd0, hwIntReq}, 32'd0);
    check("async_rst_count",    dout,              32'd0);
    check("async_rst_readHit",  {31'd0, readHit},  32'd1);
    repeat (2) cycle();
    rst   = 1'b1;
    irqIn = '0;
    repeat (4) cycle();

    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
